system_bridge: RTL
==================

SYSTEM_BRIDGE -- requirements
Module: system_bridge

Interface
REQ-001 Parameters: RAM_BASE 32'h0000_0000, RAM base address, aligned to 2^RAM_AW.
REQ-002 Parameters: RAM_AW 13, RAM window = 2^RAM_AW bytes.
REQ-003 Parameters: DEV_BASE 32'h0000_7F00, device base address, aligned to 2^DEV_AW.
REQ-004 Parameters: DEV_AW 8, device window = 2^DEV_AW bytes.
REQ-005 Parameters: TIMEOUT 15, max DEV_WAIT cycles.
REQ-006 Ports, clock and reset first:
- Clk in 1: single clock, all state on rising edge.
- Reset in 1: synchronous, active-low.
- PrAddr_I in 32: processor byte address.
- PrData_I in 32: processor write data.
- PrBE_I in 4: byte enables.
- PrReq_I in 1: bus request, held until ack.
- PrRW_I in 1: 1 read, 0 write.
- PrData_O out 32: read data to processor.
- PrAck_O out 1: one-cycle acknowledge.
- RamAddr_O out RAM_AW-2: word index.
- RamData_O out 32: RAM write data.
- RamBE_O out 4: RAM byte write enables.
- RamEn_O out 1: RAM access enable.
- RamWe_O out 1: RAM write.
- RamData_I in 32: synchronous RAM read data, valid one cycle after RamEn_O.
- DevAddr_O out DEV_AW-2: device word index.
- DevData_O out 32: device write data.
- DevBE_O out 4: device byte enables.
- DevRW_O out 1: 1 read.
- DevReq_O out 1: device request.
- DevData_I in 32: device read data.
- DevAck_I in 1: device acknowledge.
- BusErr_O out 1: sticky error flag.
- ErrAddr_O out 32: address of first error.
- ErrClr_I in 1: clears BusErr_O.

Function
REQ-007 States: IDLE, RAM_WR, RAM_RD1, RAM_RD2, DEV_WAIT, ACK, RELEASE.
REQ-008 IDLE with PrReq_I=1 at an edge: latch addr, data, BE, RW into request registers; decode on PrAddr_I.
- RAM hit (PrAddr_I[31:RAM_AW]==RAM_BASE[31:RAM_AW]) -> RAM_WR or RAM_RD1.
- DEV hit -> DEV_WAIT.
- Neither -> ACK with error.
- RAM hit takes priority if windows overlap.
REQ-009 RAM_WR: RamEn_O=1, RamWe_O=1, RamBE_O=latched BE; next state ACK.
- Write ack appears 2 cycles after the sampling edge.
REQ-010 RAM_RD1: RamEn_O=1, RamWe_O=0, RamBE_O=0, next state RAM_RD2.
REQ-011 RAM_RD2: capture RamData_I into the read-data register, next state ACK.
- Read ack appears 3 cycles after the sampling edge.
REQ-012 RAM/Dev address, data and BE outputs are driven only from latched registers, never from Pr* inputs directly.
REQ-013 DEV_WAIT entry:
- Clear the 4-bit wait counter.
- DevReq_O=1, with DevAddr/DevData/DevBE/DevRW from latched values.
REQ-014 DEV_WAIT each cycle:
- DevAck_I=1 -> capture DevData_I if read, go to ACK.
- Else counter increments; at counter==TIMEOUT with no DevAck_I -> ACK with error, read data 32'hDEAD_BEEF.
- DevAck_I on the timeout cycle wins, no error.
REQ-015 DevReq_O=0 in every state except DEV_WAIT; DevAck_I outside DEV_WAIT is ignored.
REQ-016 ACK: PrAck_O=1 for exactly one cycle, PrData_O = read-data register (0 for writes and unmapped); next state RELEASE.
REQ-017 PrData_O holds its value until the next ACK.
REQ-018 RELEASE: go to IDLE only when PrReq_I=0.
- Back-to-back requests need at least one idle cycle of PrReq_I; no double ack.
REQ-019 Error event (unmapped or timeout) in a cycle: set BusErr_O.
- Load ErrAddr_O only if BusErr_O was 0 (first error kept).
- Unmapped read data = 32'h0.
REQ-020 ErrClr_I=1 clears BusErr_O next edge; simultaneous new error and ErrClr_I: error wins, ErrAddr_O reloaded.
REQ-021 PrReq_I dropped mid-transaction does not abort; the transaction completes and ack is still issued.

Reset
REQ-022 Reset=0 at an edge: state IDLE; PrAck_O, RamEn_O, RamWe_O, DevReq_O, BusErr_O all 0; PrData_O, ErrAddr_O, request registers and counter all 0.
REQ-023 Reset mid-transaction abandons it with no ack; strobes drop the following cycle.

Verification
REQ-024 Read from RAM hit: preload word 0x1234_5678 at 0x0000_0010, read -> RamAddr_O=4, PrAck_O 3 cycles after the sampling edge, PrData_O=0x1234_5678.
REQ-025 Write to RAM hit: write 0xAABB_CCDD to 0x0000_0020 with BE=4'b0011 -> RamWe_O one cycle with RamBE_O=0011, ack 2 cycles after sampling, readback=0x0000_CCDD over 0.
REQ-026 Device access: read 0x0000_7F04, DevAck_I after 3 wait cycles with 0x55 -> DevAddr_O=1, PrData_O=0x55, BusErr_O=0.
REQ-027 Device timeout: DevAck_I never asserted -> ack after 16 DEV_WAIT cycles, PrData_O=0xDEAD_BEEF, BusErr_O=1, ErrAddr_O=0x7F04.
- Then ErrClr_I -> BusErr_O=0.
REQ-028 Unmapped access to 0x8000_0000 -> immediate ACK, data 0, BusErr_O=1.
- A second error keeps ErrAddr_O=0x8000_0000.
- PrReq_I held high after ack yields no second ack.
REQ-029 Reset during RAM_RD1 -> no PrAck_O, all outputs 0 the next cycle, and a new request then completes normally.

Source files
------------

// File: rtl/system_bridge.sv
// Processor-to-memory bridge: decodes single processor requests onto a synchronous
// RAM window or a handshake device window, with device timeout and sticky error capture.
module system_bridge #(
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter int unsigned RAM_AW   = 13,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter int unsigned DEV_AW   = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       PrAddr_I,
    input  logic [31:0]       PrData_I,
    input  logic [3:0]        PrBE_I,
    input  logic              PrReq_I,
    input  logic              PrRW_I,
    output logic [31:0]       PrData_O,
    output logic              PrAck_O,
    output logic [RAM_AW-3:0] RamAddr_O,
    output logic [31:0]       RamData_O,
    output logic [3:0]        RamBE_O,
    output logic              RamEn_O,
    output logic              RamWe_O,
    input  logic [31:0]       RamData_I,
    output logic [DEV_AW-3:0] DevAddr_O,
    output logic [31:0]       DevData_O,
    output logic [3:0]        DevBE_O,
    output logic              DevRW_O,
    output logic              DevReq_O,
    input  logic [31:0]       DevData_I,
    input  logic              DevAck_I,
    output logic              BusErr_O,
    output logic [31:0]       ErrAddr_O,
    input  logic              ErrClr_I
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RAM_WR   = 3'd1;
    localparam logic [2:0] RAM_RD1  = 3'd2;
    localparam logic [2:0] RAM_RD2  = 3'd3;
    localparam logic [2:0] DEV_WAIT = 3'd4;
    localparam logic [2:0] ACK      = 3'd5;
    localparam logic [2:0] RELEASE  = 3'd6;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    logic [2:0]  state;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic        req_rw;
    logic [31:0] rd_data;
    logic [3:0]  wait_cnt;

    logic        ram_hit;
    logic        dev_hit;
    logic        err_event;
    logic [31:0] err_addr;

    assign ram_hit = (PrAddr_I[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
    assign dev_hit = (PrAddr_I[31:DEV_AW] == DEV_BASE[31:DEV_AW]);

    // Unmapped is detected on the live address at acceptance; timeout uses the latched one.
    always_comb begin
        err_event = 1'b0;
        err_addr  = req_addr;
        if (state == IDLE && PrReq_I && !ram_hit && !dev_hit) begin
            err_event = 1'b1;
            err_addr  = PrAddr_I;
        end else if (state == DEV_WAIT && !DevAck_I && wait_cnt == TIMEOUT_CNT) begin
            err_event = 1'b1;
        end
    end

    assign RamAddr_O = req_addr[RAM_AW-1:2];
    assign RamData_O = req_data;
    assign RamBE_O   = (state == RAM_WR) ? req_be : '0;
    assign RamEn_O   = (state == RAM_WR) || (state == RAM_RD1);
    assign RamWe_O   = (state == RAM_WR);

    assign DevAddr_O = req_addr[DEV_AW-1:2];
    assign DevData_O = req_data;
    assign DevBE_O   = req_be;
    assign DevRW_O   = req_rw;
    assign DevReq_O  = (state == DEV_WAIT);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_data  <= '0;
            req_be    <= '0;
            req_rw    <= 1'b0;
            rd_data   <= '0;
            wait_cnt  <= '0;
            PrAck_O   <= 1'b0;
            PrData_O  <= '0;
            BusErr_O  <= 1'b0;
            ErrAddr_O <= '0;
        end else begin
            PrAck_O <= (state == ACK);
            if (state == ACK) begin
                PrData_O <= rd_data;
            end

            // A new error outranks a same-cycle clear and then refreshes the captured address.
            if (err_event) begin
                BusErr_O <= 1'b1;
                if (!BusErr_O || ErrClr_I) begin
                    ErrAddr_O <= err_addr;
                end
            end else if (ErrClr_I) begin
                BusErr_O <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (PrReq_I) begin
                        req_addr <= PrAddr_I;
                        req_data <= PrData_I;
                        req_be   <= PrBE_I;
                        req_rw   <= PrRW_I;
                        rd_data  <= '0;
                        if (ram_hit) begin
                            state <= PrRW_I ? RAM_RD1 : RAM_WR;
                        end else if (dev_hit) begin
                            wait_cnt <= '0;
                            state    <= DEV_WAIT;
                        end else begin
                            state <= ACK;
                        end
                    end
                end
                RAM_WR:  state <= ACK;
                RAM_RD1: state <= RAM_RD2;
                RAM_RD2: begin
                    rd_data <= RamData_I;
                    state   <= ACK;
                end
                DEV_WAIT: begin
                    if (DevAck_I) begin
                        if (req_rw) begin
                            rd_data <= DevData_I;
                        end
                        state <= ACK;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        rd_data <= 32'hDEAD_BEEF;
                        state   <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACK:     state <= RELEASE;
                RELEASE: begin
                    if (!PrReq_I) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
